// File: rtl/rep_sequencer.sv
// rep_sequencer: steps the combinational execute block through x86 string
// instructions (MOVS/CMPS-class, optional REP/REPE/REPNE prefix).
//
// Ports:
//   clk, rst_n (async, active low), flush (synchronous abort, no retirement)
//   start_valid/start_ready + rep_mode/cmp_kind/opc_in/size_in + ECX/ESI/EDI/EFLAGS in
//   mem_req_* : read request at (ESI, EDI); mem_rsp_* : read operands back
//   mem_wr_*  : write of execute result to EDI (non-compare forms only)
//   exe_*     : operands/flags/opcode to execute, exe_o_eflags/exe_opnd0_w back
//   done_valid/done_ready + ECX/ESI/EDI/EFLAGS out : retirement
module rep_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [1:0]  rep_mode,
  input  logic        cmp_kind,
  input  logic [5:0]  opc_in,
  input  logic [1:0]  size_in,
  input  logic [31:0] ecx_in,
  input  logic [31:0] esi_in,
  input  logic [31:0] edi_in,
  input  logic [31:0] eflags_in,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_src_addr,
  output logic [31:0] mem_dst_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_opnd0,
  input  logic [31:0] mem_rsp_opnd1,
  output logic        mem_wr_valid,
  input  logic        mem_wr_ready,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic [5:0]  exe_opc,
  output logic [31:0] exe_eflags,
  output logic [31:0] exe_opnd0,
  output logic [31:0] exe_opnd1,
  input  logic [31:0] exe_o_eflags,
  input  logic [31:0] exe_opnd0_w,
  output logic        done_valid,
  input  logic        done_ready,
  output logic [31:0] ecx_out,
  output logic [31:0] esi_out,
  output logic [31:0] edi_out,
  output logic [31:0] eflags_out
);

  typedef enum logic [2:0] {IDLE, CHECK, REQ, WAIT, EXEC, DONE} state_e;

  localparam int DF_BIT = 10;
  localparam int ZF_BIT = 6;

  state_e      state_q, state_d;
  logic [1:0]  rep_q, rep_d;
  logic        cmp_q, cmp_d;
  logic [5:0]  opc_q, opc_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] ecx_q, ecx_d, esi_q, esi_d, edi_q, edi_d, efl_q, efl_d;
  logic [31:0] op0_q, op0_d, op1_q, op1_d;

  logic [31:0] step;
  logic        commit;
  logic        zf_new;

  always_comb begin
    case (size_q)
      2'b00:   step = 32'd1;
      2'b01:   step = 32'd2;
      default: step = 32'd4;
    endcase
  end

  // Compare forms never write, so they commit the first cycle in EXEC.
  assign commit = (state_q == EXEC) && (cmp_q || mem_wr_ready);
  assign zf_new = exe_o_eflags[ZF_BIT];

  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    cmp_d   = cmp_q;
    opc_d   = opc_q;
    size_d  = size_q;
    ecx_d   = ecx_q;
    esi_d   = esi_q;
    edi_d   = edi_q;
    efl_d   = efl_q;
    op0_d   = op0_q;
    op1_d   = op1_q;
    case (state_q)
      IDLE: if (start_valid) begin
        // Encoding 11 is folded to "no prefix" at capture time.
        rep_d   = (rep_mode == 2'b11) ? 2'b00 : rep_mode;
        cmp_d   = cmp_kind;
        opc_d   = opc_in;
        size_d  = size_in;
        ecx_d   = ecx_in;
        esi_d   = esi_in;
        edi_d   = edi_in;
        efl_d   = eflags_in;
        state_d = CHECK;
      end
      CHECK: state_d = (rep_q != 2'b00 && ecx_q == '0) ? DONE : REQ;
      REQ:   if (mem_req_ready) state_d = WAIT;
      WAIT: if (mem_rsp_valid) begin
        op0_d   = mem_rsp_opnd0;
        op1_d   = mem_rsp_opnd1;
        state_d = EXEC;
      end
      EXEC: if (commit) begin
        efl_d = exe_o_eflags;
        // Direction comes from the flags in force for this iteration.
        esi_d = efl_q[DF_BIT] ? esi_q - step : esi_q + step;
        edi_d = efl_q[DF_BIT] ? edi_q - step : edi_q + step;
        if (rep_q != 2'b00) ecx_d = ecx_q - 32'd1;
        // Count exhaustion is tested first; either way the result is DONE.
        if (rep_q == 2'b00 || ecx_d == '0)          state_d = DONE;
        else if (cmp_q && rep_q == 2'b01 && !zf_new) state_d = DONE;
        else if (cmp_q && rep_q == 2'b10 && zf_new)  state_d = DONE;
        else                                         state_d = REQ;
      end
      DONE:    if (done_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rep_q   <= '0;
      cmp_q   <= 1'b0;
      opc_q   <= '0;
      size_q  <= '0;
      ecx_q   <= '0;
      esi_q   <= '0;
      edi_q   <= '0;
      efl_q   <= '0;
      op0_q   <= '0;
      op1_q   <= '0;
    end else if (flush) begin
      // Abort: architectural latches keep their values but are not retired.
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
      rep_q   <= rep_d;
      cmp_q   <= cmp_d;
      opc_q   <= opc_d;
      size_q  <= size_d;
      ecx_q   <= ecx_d;
      esi_q   <= esi_d;
      edi_q   <= edi_d;
      efl_q   <= efl_d;
      op0_q   <= op0_d;
      op1_q   <= op1_d;
    end
  end

  assign start_ready   = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign mem_src_addr  = esi_q;
  assign mem_dst_addr  = edi_q;
  assign mem_wr_valid  = (state_q == EXEC) && !cmp_q;
  assign mem_wr_addr   = edi_q;
  // Gated so the write bus reads 0 outside a write, including after reset.
  assign mem_wr_data   = mem_wr_valid ? exe_opnd0_w : '0;
  assign exe_opc       = opc_q;
  assign exe_eflags    = efl_q;
  assign exe_opnd0     = op0_q;
  assign exe_opnd1     = op1_q;
  assign done_valid    = (state_q == DONE);
  assign ecx_out       = ecx_q;
  assign esi_out       = esi_q;
  assign edi_out       = edi_q;
  assign eflags_out    = efl_q;

endmodule

// File: tb/tb_rep_sequencer.sv
// Self-checking bench for rep_sequencer: a stub execute unit, a randomized
// memory/retire environment, and an instruction-level reference model.
module tb_rep_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, flush, start_valid, start_ready;
  logic [1:0]  rep_mode, size_in;
  logic        cmp_kind;
  logic [5:0]  opc_in;
  logic [31:0] ecx_in, esi_in, edi_in, eflags_in;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_src_addr, mem_dst_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_opnd0, mem_rsp_opnd1;
  logic        mem_wr_valid, mem_wr_ready;
  logic [31:0] mem_wr_addr, mem_wr_data;
  logic [5:0]  exe_opc;
  logic [31:0] exe_eflags, exe_opnd0, exe_opnd1, exe_o_eflags, exe_opnd0_w;
  logic        done_valid, done_ready;
  logic [31:0] ecx_out, esi_out, edi_out, eflags_out;

  localparam logic [31:0] XK = 32'hA5A5_0F0F;

  always #5 clk = ~clk;

  rep_sequencer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .start_valid(start_valid), .start_ready(start_ready),
    .rep_mode(rep_mode), .cmp_kind(cmp_kind), .opc_in(opc_in), .size_in(size_in),
    .ecx_in(ecx_in), .esi_in(esi_in), .edi_in(edi_in), .eflags_in(eflags_in),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_src_addr(mem_src_addr), .mem_dst_addr(mem_dst_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_opnd0(mem_rsp_opnd0), .mem_rsp_opnd1(mem_rsp_opnd1),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .exe_opc(exe_opc), .exe_eflags(exe_eflags), .exe_opnd0(exe_opnd0), .exe_opnd1(exe_opnd1),
    .exe_o_eflags(exe_o_eflags), .exe_opnd0_w(exe_opnd0_w),
    .done_valid(done_valid), .done_ready(done_ready),
    .ecx_out(ecx_out), .esi_out(esi_out), .edi_out(edi_out), .eflags_out(eflags_out)
  );

  // Execute stub: ZF = (opnd0 == opnd1), other flags pass through; result = opnd0 ^ XK.
  assign exe_o_eflags = (exe_eflags & ~32'h40) | ((exe_opnd0 == exe_opnd1) ? 32'h40 : 32'h0);
  assign exe_opnd0_w  = exe_opnd0 ^ XK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-iteration memory operands, plus the model's expected trace/results.
  logic [31:0] op0 [16];
  logic [31:0] op1 [16];
  logic [31:0] m_src [16];
  logic [31:0] m_dst [16];
  logic [31:0] m_wa [$];
  logic [31:0] m_wd [$];
  int          m_iters;
  logic [31:0] m_ecx, m_esi, m_edi, m_efl;

  task automatic model(input logic [1:0] rep, input logic cmp, input logic [1:0] sz,
                       input logic [31:0] ecx, input logic [31:0] esi,
                       input logic [31:0] edi, input logic [31:0] efl);
    int rn, stp;
    bit eq;
    rn = (rep == 2'b11) ? 0 : int'(rep);
    stp = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    m_iters = 0; m_wa.delete(); m_wd.delete();
    m_ecx = ecx; m_esi = esi; m_edi = edi; m_efl = efl;
    if (rn != 0 && ecx == 0) return;
    while (m_iters < 16) begin
      m_src[m_iters] = m_esi;
      m_dst[m_iters] = m_edi;
      eq = (op0[m_iters] == op1[m_iters]);
      if (!cmp) begin m_wa.push_back(m_edi); m_wd.push_back(op0[m_iters] ^ XK); end
      if (m_efl[10]) begin m_esi -= stp; m_edi -= stp; end
      else           begin m_esi += stp; m_edi += stp; end
      m_efl[6] = eq;
      if (rn != 0) m_ecx -= 1;
      m_iters++;
      if (rn == 0 || m_ecx == 0) break;
      if (cmp && rn == 1 && !eq) break;
      if (cmp && rn == 2 && eq) break;
    end
  endtask

  task automatic fill_ops(input int eq_pct);
    for (int k = 0; k < 16; k++) begin
      op0[k] = $urandom;
      op1[k] = ($urandom_range(0, 99) < eq_pct) ? op0[k] : $urandom;
    end
  endtask

  // Runs one instruction to retirement; bp forces 4-cycle stalls on every ready.
  task automatic run(input logic [1:0] rep, input logic cmp, input logic [1:0] sz,
                     input logic [31:0] ecx, input logic [31:0] esi, input logic [31:0] edi,
                     input logic [31:0] efl, input bit bp, input bit lat_chk);
    int cyc, req_n, wr_n, pdel, sq, sw, sd;
    bit pend, done, seen_done, rdy;
    logic [5:0] opc;
    model(rep, cmp, sz, ecx, esi, edi, efl);
    opc = 6'($urandom);
    @(negedge clk);
    chk("start_ready_idle", start_ready, 1);
    start_valid = 1; rep_mode = rep; cmp_kind = cmp; size_in = sz; opc_in = opc;
    ecx_in = ecx; esi_in = esi; edi_in = edi; eflags_in = efl;
    @(negedge clk);
    start_valid = 0; ecx_in = $urandom; esi_in = $urandom; edi_in = $urandom;
    cyc = 1; req_n = 0; wr_n = 0; pend = 0; pdel = 0; done = 0; seen_done = 0;
    sq = 0; sw = 0; sd = 0;
    while (!done && cyc < 400) begin
      chk("exe_opc", exe_opc, opc);
      // response goes out no earlier than the cycle after the request handshake
      if (pend && pdel == 0) begin
        mem_rsp_valid = 1; mem_rsp_opnd0 = op0[req_n-1]; mem_rsp_opnd1 = op1[req_n-1]; pend = 0;
      end else begin
        mem_rsp_valid = 0; mem_rsp_opnd0 = $urandom; mem_rsp_opnd1 = $urandom;
        if (pend) pdel--;
      end
      if (mem_req_valid) begin
        chk("busy_start_ready", start_ready, 0);
        if (req_n < m_iters) begin
          chk("req_src", mem_src_addr, m_src[req_n]);
          chk("req_dst", mem_dst_addr, m_dst[req_n]);
        end else chk("req_extra", 1, 0);
        rdy = bp ? (sq >= 4) : bit'($urandom_range(0, 1));
        sq = rdy ? 0 : sq + 1;
        mem_req_ready = rdy;
        if (rdy) begin req_n++; pend = 1; pdel = bp ? 0 : $urandom_range(0, 2); end
      end else mem_req_ready = bit'($urandom_range(0, 1));
      if (mem_wr_valid) begin
        chk("busy_start_ready", start_ready, 0);
        if (wr_n < m_wa.size()) begin
          chk("wr_addr", mem_wr_addr, m_wa[wr_n]);
          chk("wr_data", mem_wr_data, m_wd[wr_n]);
        end else chk("wr_extra", 1, 0);
        rdy = bp ? (sw >= 4) : bit'($urandom_range(0, 1));
        sw = rdy ? 0 : sw + 1;
        mem_wr_ready = rdy;
        if (rdy) wr_n++;
      end else mem_wr_ready = bit'($urandom_range(0, 1));
      if (done_valid) begin
        if (lat_chk && !seen_done) chk("done_latency", 64'(cyc), 2);
        seen_done = 1;
        chk("busy_start_ready", start_ready, 0);
        chk("ecx_out", ecx_out, m_ecx);
        chk("esi_out", esi_out, m_esi);
        chk("edi_out", edi_out, m_edi);
        chk("eflags_out", eflags_out, m_efl);
        rdy = bp ? (sd >= 4) : bit'($urandom_range(0, 1));
        sd = rdy ? 0 : sd + 1;
        done_ready = rdy;
        if (rdy) begin
          done = 1;
          chk("iterations", 64'(req_n), 64'(m_iters));
          chk("write_count", 64'(wr_n), 64'(m_wa.size()));
        end
      end else done_ready = bit'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    if (!done) chk("timeout", 0, 1);
    mem_rsp_valid = 0; mem_req_ready = 0; mem_wr_ready = 0; done_ready = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start_ready"}, start_ready, 1);
    chk({tag, "_valids"}, {mem_req_valid, mem_wr_valid, done_valid}, 0);
    chk({tag, "_exe"}, {exe_opc, exe_eflags, exe_opnd0, exe_opnd1}, 0);
    chk({tag, "_addr"}, {mem_src_addr, mem_dst_addr, mem_wr_addr, mem_wr_data}, 0);
    chk({tag, "_retire"}, {ecx_out, esi_out, edi_out, eflags_out}, 0);
  endtask

  initial begin
    rst_n = 0; flush = 0; start_valid = 0; rep_mode = 0; cmp_kind = 0; size_in = 0;
    opc_in = 0; ecx_in = 0; esi_in = 0; edi_in = 0; eflags_in = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_opnd0 = 0; mem_rsp_opnd1 = 0;
    mem_wr_ready = 0; done_ready = 0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1;

    // MOVS dword REP ECX=3 forward
    fill_ops(50);
    run(2'b01, 1'b0, 2'b10, 32'd3, 32'h100, 32'h200, 32'h0, 0, 0);
    // CMPS byte REPE ECX=5, mismatch on the second compare, both directions
    fill_ops(100); op1[1] = ~op0[1];
    run(2'b01, 1'b1, 2'b00, 32'd5, 32'h1000, 32'h2000, 32'h2, 0, 0);
    run(2'b01, 1'b1, 2'b00, 32'd5, 32'h1000, 32'h2000, 32'h402, 0, 0);
    // CMPS word REPNE stops on the first match
    fill_ops(0); op1[2] = op0[2];
    run(2'b10, 1'b1, 2'b01, 32'd6, 32'h40, 32'h80, 32'h0, 0, 0);
    // REP with ECX=0: no iterations, done two cycles after start
    run(2'b01, 1'b0, 2'b10, 32'd0, 32'h55, 32'h66, 32'h8D5, 0, 1);
    // No prefix, word MOVS, ESI wraps
    fill_ops(50);
    run(2'b00, 1'b0, 2'b01, 32'd7, 32'hFFFF_FFFF, 32'h10, 32'h0, 0, 0);
    // rep_mode 11 behaves as no prefix
    run(2'b11, 1'b0, 2'b10, 32'd9, 32'h300, 32'h400, 32'h400, 0, 0);
    // back-pressure on every handshake
    fill_ops(50);
    run(2'b01, 1'b0, 2'b10, 32'd2, 32'h500, 32'h600, 32'h0, 1, 0);

    for (int t = 0; t < 40; t++) begin
      logic [1:0] rp;
      rp = 2'($urandom_range(0, 3));
      fill_ops(60);
      run(rp, 1'($urandom), 2'($urandom), (rp == 2'b00) ? $urandom : $urandom_range(0, 7),
          $urandom, $urandom, $urandom & 32'h0000_0FFF, 1'($urandom_range(0, 3) == 0), 0);
    end

    // flush while waiting for read data
    @(negedge clk);
    start_valid = 1; rep_mode = 2'b01; cmp_kind = 0; size_in = 2'b10; opc_in = 6'h2A;
    ecx_in = 3; esi_in = 32'h100; edi_in = 32'h200; eflags_in = 0; mem_req_ready = 1;
    @(negedge clk); start_valid = 0;
    @(negedge clk); chk("flush_req_valid", mem_req_valid, 1);
    @(negedge clk); flush = 1;
    @(negedge clk); flush = 0;
    chk("flush_idle", {start_ready, mem_req_valid, mem_wr_valid, done_valid}, 4'b1000);
    mem_rsp_valid = 1; mem_rsp_opnd0 = 32'h1234; mem_rsp_opnd1 = 32'h1234;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); mem_rsp_valid = 0;
      chk("flush_no_done", {mem_req_valid, mem_wr_valid, done_valid}, 0);
    end

    // async reset while a write is held in EXEC
    start_valid = 1; mem_req_ready = 1; mem_wr_ready = 0;
    @(negedge clk); start_valid = 0;
    @(negedge clk);
    @(negedge clk); mem_rsp_valid = 1; mem_rsp_opnd0 = 32'h77; mem_rsp_opnd1 = 32'h88;
    @(negedge clk); mem_rsp_valid = 0;
    chk("exec_wr_valid", {mem_wr_valid, done_valid}, 2'b10);
    #2 rst_n = 0;
    #1 chk_all_zero("async_reset");
    @(negedge clk); rst_n = 1; mem_req_ready = 0;
    repeat (2) begin
      @(negedge clk);
      chk("post_reset_idle", {start_ready, mem_req_valid, done_valid}, 3'b100);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
